// File: rtl/monster_line_renderer.sv
// Per-line monster sprite list builder and per-pixel hit test for the VGA pipeline.
// Optional MONSTER_SNAPSHOT_EN: scans read a shadow copy of state_monsters latched on frame_start.

module mlr_hit_lane #(
  parameter int SPRITE = 32,
  parameter int RW     = 5
) (
  input  logic          ent_vld,
  input  logic [10:0]   x0,
  input  logic [9:0]    px,
  output logic          lane_hit,
  output logic [RW-1:0] lane_col
);
  logic [10:0] px_w, dx;

  assign px_w     = {1'b0, px};
  assign dx       = px_w - x0;
  assign lane_hit = ent_vld && (px_w >= x0) && (px_w <= x0 + 11'(SPRITE-1));
  assign lane_col = dx[RW-1:0];
endmodule

module monster_line_renderer #(
  parameter  int MONSTERS     = 12,
  parameter  int MAX_PER_LINE = 4,
  parameter  int SPRITE       = 32,
  parameter  int SCALE_SHIFT  = 2,
  localparam int RW           = $clog2(SPRITE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [19*MONSTERS-1:0]  state_monsters,
  input  logic                    frame_start,
  input  logic                    line_start,
  input  logic [9:0]              next_y,
  input  logic                    pixel_valid,
  input  logic [9:0]              pixel_x,
  output logic                    hit,
  output logic [3:0]              hit_slot,
  output logic [1:0]              hit_dir,
  output logic [RW-1:0]           hit_row,
  output logic [RW-1:0]           hit_col,
  output logic                    busy,
  output logic                    overflow,
  output logic                    overrun
);
  localparam int SW = $clog2(MONSTERS);
  localparam int CW = $clog2(MAX_PER_LINE+1);

  typedef struct packed {
    logic          vld;
    logic [3:0]    slot;
    logic [1:0]    dir;
    logic [10:0]   x0;
    logic [RW-1:0] row;
  } ent_t;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                   state;
  logic [SW-1:0]            scan_idx;
  logic [CW-1:0]            prep_cnt, cnt_nxt;
  logic [10:0]              ny_q;
  ent_t [MAX_PER_LINE-1:0]  prep_buf, act_buf, prep_nxt;
  logic [19*MONSTERS-1:0]   src;

`ifdef MONSTER_SNAPSHOT_EN
  logic [19*MONSTERS-1:0] shadow;
  always_ff @(posedge clk) begin
    if (rst)              shadow <= '0;
    else if (frame_start) shadow <= state_monsters;
  end
  assign src = shadow;
`else
  assign src = state_monsters;
`endif

  // Slot under scan: decode and test against the latched line
  logic [18:0] cur;
  logic [10:0] y0, x0, dy;
  logic        match, ovf_set;

  assign cur   = src[19*int'(scan_idx) +: 19];
  assign y0    = 11'(cur[18:11]) << SCALE_SHIFT;
  assign x0    = 11'(cur[10:3]) << SCALE_SHIFT;
  assign dy    = ny_q - y0;
  assign match = (state == SCAN) && cur[0] && (ny_q >= y0) && (ny_q <= y0 + 11'(SPRITE-1));

  always_comb begin
    prep_nxt = prep_buf;
    cnt_nxt  = prep_cnt;
    ovf_set  = 1'b0;
    if (match) begin
      if (prep_cnt < CW'(MAX_PER_LINE)) begin
        for (int i = 0; i < MAX_PER_LINE; i++)
          if (CW'(i) == prep_cnt)
            prep_nxt[i] = '{vld: 1'b1, slot: 4'(scan_idx), dir: cur[2:1], x0: x0, row: dy[RW-1:0]};
        cnt_nxt = prep_cnt + 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  // The current slot still lands in the list on the line_start edge, so an
  // interrupted scan hands over everything it examined.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      scan_idx <= '0;
      prep_cnt <= '0;
      prep_buf <= '0;
      act_buf  <= '0;
      ny_q     <= '0;
      overflow <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (ovf_set) overflow <= 1'b1;
      if (line_start) begin
        act_buf  <= frame_start ? '0 : prep_nxt;
        prep_buf <= '0;
        prep_cnt <= '0;
        ny_q     <= {1'b0, next_y};
        scan_idx <= '0;
        state    <= SCAN;
        busy     <= 1'b1;
        if (state == SCAN) overrun <= 1'b1;
      end else if (frame_start) begin
        act_buf  <= '0;
        prep_buf <= '0;
        prep_cnt <= '0;
        if (state == SCAN) scan_idx <= scan_idx + 1'b1;
      end else if (state == SCAN) begin
        prep_buf <= prep_nxt;
        prep_cnt <= cnt_nxt;
        if (scan_idx == SW'(MONSTERS-1)) begin
          act_buf  <= prep_nxt;
          scan_idx <= '0;
          state    <= IDLE;
          busy     <= 1'b0;
        end else begin
          scan_idx <= scan_idx + 1'b1;
        end
      end
    end
  end

  logic [MAX_PER_LINE-1:0]         lane_hit;
  logic [MAX_PER_LINE-1:0][RW-1:0] lane_col;

  for (genvar g = 0; g < MAX_PER_LINE; g++) begin : g_lane
    mlr_hit_lane #(.SPRITE(SPRITE), .RW(RW)) u_lane (
      .ent_vld  (act_buf[g].vld),
      .x0       (act_buf[g].x0),
      .px       (pixel_x),
      .lane_hit (lane_hit[g]),
      .lane_col (lane_col[g])
    );
  end

  ent_t          win_ent;
  logic          win_hit;
  logic [RW-1:0] win_col;

  // Lowest list index wins; list order is slot order
  always_comb begin
    win_hit = 1'b0;
    win_ent = '0;
    win_col = '0;
    for (int i = MAX_PER_LINE-1; i >= 0; i--)
      if (lane_hit[i]) begin
        win_hit = 1'b1;
        win_ent = act_buf[i];
        win_col = lane_col[i];
      end
  end

  always_ff @(posedge clk) begin
    if (rst || !(pixel_valid && win_hit)) begin
      hit      <= 1'b0;
      hit_slot <= '0;
      hit_dir  <= '0;
      hit_row  <= '0;
      hit_col  <= '0;
    end else begin
      hit      <= 1'b1;
      hit_slot <= win_ent.slot;
      hit_dir  <= win_ent.dir;
      hit_row  <= win_ent.row;
      hit_col  <= win_col;
    end
  end
endmodule

// File: tb/tb_monster_line_renderer.sv
// Randomized + directed bench for monster_line_renderer against a list-level reference model.
module tb_monster_line_renderer;
  localparam int NM = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [19*NM-1:0] state_monsters = '0;
  logic          frame_start = 1'b0, line_start = 1'b0, pixel_valid = 1'b0;
  logic [9:0]    next_y = '0, pixel_x = '0;
  logic          hit, busy, overflow, overrun;
  logic [3:0]    hit_slot;
  logic [1:0]    hit_dir;
  logic [4:0]    hit_row, hit_col;

  monster_line_renderer dut (
    .clk(clk), .rst(rst), .state_monsters(state_monsters),
    .frame_start(frame_start), .line_start(line_start), .next_y(next_y),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x),
    .hit(hit), .hit_slot(hit_slot), .hit_dir(hit_dir), .hit_row(hit_row), .hit_col(hit_col),
    .busy(busy), .overflow(overflow), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: monster table and the list of sprites on the displayed line
  typedef struct { int slot; int dir; int x0; int row; } ent_m;
  logic       m_alive [NM];
  logic [1:0] m_dir   [NM];
  logic [7:0] m_x     [NM];
  logic [7:0] m_y     [NM];
  ent_m lst[$];
  bit   exp_ovf = 0, exp_ovr = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19*NM-1:0] pack();
    logic [19*NM-1:0] p;
    for (int i = 0; i < NM; i++) p[i*19 +: 19] = {m_y[i], m_x[i], m_dir[i], m_alive[i]};
    return p;
  endfunction

  function automatic void clear_table();
    for (int i = 0; i < NM; i++) begin
      m_alive[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
  endfunction

  function automatic void model_line(int ny, int nslots);
    lst.delete();
    for (int s = 0; s < nslots; s++) begin
      int y0 = int'(m_y[s]) * 4;
      if (m_alive[s] && ny >= y0 && ny <= y0 + 31) begin
        if (lst.size() < 4) lst.push_back('{s, int'(m_dir[s]), int'(m_x[s]) * 4, ny - y0});
        else exp_ovf = 1;
      end
    end
  endfunction

  // Drive the table and start a frame so snapshot and live builds agree
  task automatic load_frame();
    state_monsters = pack();
    frame_start = 1; step(); frame_start = 0;
    lst.delete();
  endtask

  task automatic do_line(input int ny);
    next_y = 10'(ny); line_start = 1; step(); line_start = 0;
    chk("busy_start", busy, 1);
    repeat (NM-1) step();
    chk("busy_last", busy, 1);
    step();
    chk("busy_end", busy, 0);
    model_line(ny, NM);
    chk("overflow", overflow, exp_ovf);
    chk("overrun", overrun, exp_ovr);
  endtask

  task automatic check_pix(input int px, input bit v);
    bit eh = 0;
    int es = 0, ed = 0, er = 0, ec = 0;
    pixel_x = 10'(px); pixel_valid = v; step(); pixel_valid = 0;
    if (v)
      foreach (lst[k])
        if (!eh && px >= lst[k].x0 && px <= lst[k].x0 + 31) begin
          eh = 1; es = lst[k].slot; ed = lst[k].dir; er = lst[k].row; ec = px - lst[k].x0;
        end
    chk($sformatf("hit@%0d", px), hit, eh);
    chk($sformatf("slot@%0d", px), hit_slot, es);
    chk($sformatf("dir@%0d", px), hit_dir, ed);
    chk($sformatf("row@%0d", px), hit_row, er);
    chk($sformatf("col@%0d", px), hit_col, ec);
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
    lst.delete(); exp_ovf = 0; exp_ovr = 0;
  endtask

  initial begin
    clear_table();
    repeat (2) step();
    rst = 0;
    chk("rst_hit", hit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_slot", hit_slot, 0);

    // Single monster
    m_alive[0] = 1; m_dir[0] = 2; m_x[0] = 10; m_y[0] = 20;
    load_frame();
    do_line(85);
    check_pix(45, 1);
    chk("single_row", hit_row, 5);
    check_pix(39, 1);
    check_pix(72, 1);
    check_pix(71, 1);
    check_pix(45, 0);

    // Priority: lower slot wins
    clear_table();
    m_alive[3] = 1; m_dir[3] = 1; m_x[3] = 10; m_y[3] = 20;
    m_alive[7] = 1; m_dir[7] = 3; m_x[7] = 10; m_y[7] = 20;
    load_frame();
    check_pix(40, 1);
    do_line(80);
    check_pix(40, 1);
    chk("prio_slot", hit_slot, 3);

    // Dead slot ignored; bottom-edge monster does not wrap
    clear_table();
    m_alive[0] = 0; m_x[0] = 0; m_y[0] = 255;
    m_alive[1] = 1; m_dir[1] = 1; m_x[1] = 0; m_y[1] = 255;
    load_frame();
    do_line(1023);
    check_pix(10, 1);
    chk("edge_row", hit_row, 3);
    m_alive[1] = 0; m_alive[2] = 1; m_y[2] = 0;
    load_frame();
    do_line(1023);
    check_pix(10, 1);

    // Overflow: six on one line, only four listed
    clear_table();
    for (int i = 0; i < 6; i++) begin
      m_alive[i] = 1; m_dir[i] = 2'(i); m_y[i] = 20;
    end
    m_x[0] = 0; m_x[1] = 20; m_x[2] = 40; m_x[3] = 60; m_x[4] = 100; m_x[5] = 120;
    load_frame();
    do_line(90);
    chk("ovf_set", overflow, 1);
    check_pix(400, 1);
    check_pix(490, 1);
    check_pix(271, 1);
    do_line(500);
    chk("ovf_sticky", overflow, 1);

    // Overrun: second line_start while slot 4 is being examined
    clear_table();
    foreach (m_alive[i]) m_x[i] = 8'(i * 20);
    m_alive[0] = 1; m_y[0] = 25; m_alive[2] = 1; m_y[2] = 25;
    m_alive[4] = 1; m_y[4] = 25; m_dir[4] = 3; m_alive[6] = 1; m_y[6] = 25;
    m_alive[1] = 1; m_y[1] = 75; m_alive[8] = 1; m_y[8] = 74;
    load_frame();
    next_y = 10'd100; line_start = 1; step(); line_start = 0;
    repeat (4) step();
    next_y = 10'd300; line_start = 1; step(); line_start = 0;
    exp_ovr = 1;
    chk("ovr_set", overrun, 1);
    model_line(100, 5);
    check_pix(4 * 80 + 7, 1);
    check_pix(4 * 120 + 7, 1);
    check_pix(2, 1);
    for (int k = 0; k < 20 && busy; k++) step();
    chk("ovr_done", busy, 0);
    model_line(300, NM);
    check_pix(4 * 20 + 3, 1);
    check_pix(4 * 160 + 9, 1);
    check_pix(4 * 80 + 7, 1);
    chk("ovr_sticky", overrun, 1);

    // Reset during a scan
    next_y = 10'd300; line_start = 1; step(); line_start = 0;
    repeat (3) step();
    pixel_x = 10'd83; pixel_valid = 1;
    do_reset();
    pixel_valid = 0;
    chk("mrst_busy", busy, 0);
    chk("mrst_hit", hit, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_ovr", overrun, 0);
    check_pix(83, 1);

    // Randomized lines
    for (int it = 0; it < 30; it++) begin
      int ny = $urandom_range(0, 1023);
      for (int i = 0; i < NM; i++) begin
        int yy = ny / 4 - $urandom_range(0, 10) + 1;
        m_alive[i] = ($urandom_range(0, 2) != 0);
        m_dir[i]   = 2'($urandom);
        m_x[i]     = 8'($urandom);
        m_y[i]     = 8'((yy < 0) ? 0 : (yy > 255) ? 255 : yy);
      end
      load_frame();
      if (it % 5 == 0) check_pix(int'(m_x[0]) * 4, 1);
      do_line(ny);
      for (int p = 0; p < 8; p++) begin
        int px = int'(m_x[$urandom_range(0, NM-1)]) * 4 + $urandom_range(0, 40) - 5;
        px = (px < 0) ? 0 : (px > 1023) ? 1023 : px;
        check_pix(px, ($urandom_range(0, 7) != 0));
      end
    end

`ifdef MONSTER_SNAPSHOT_EN
    // Mid-frame table changes stay invisible until the next frame_start
    do_reset();
    clear_table();
    m_alive[0] = 1; m_dir[0] = 2; m_x[0] = 10; m_y[0] = 20;
    load_frame();
    do_line(85);
    check_pix(45, 1);
    state_monsters = '0;
    do_line(85);
    check_pix(45, 1);
    chk("snap_hold", hit, 1);
    clear_table();
    frame_start = 1; step(); frame_start = 0;
    lst.delete();
    do_line(85);
    check_pix(45, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
